i8088_bus_slave: RTL and testbench
==================================

# i8088_bus_slave

Bus-cycle slave that sits directly downstream of the Intel 8088 pin bundle. It demultiplexes the address/data bus on ALE into a 20-bit address and decodes one memory or I/O window. It converts RD/WR strobes into single-cycle memory-side read/write pulses, inserts programmable wait states through READY, and drives read data back onto AD. It is the block that produces the `Address`/`Data` view consumed by peripherals.

## Interface
Parameters:
- `BASE_ADDR`, 20'h00000: first address of the decoded window.
- `WIN_LOG2`, 16: window size is 2**WIN_LOG2 bytes; the window must be aligned to its size.
- `IS_IO`, 0: 0 responds to memory cycles (IOM=0), 1 responds to I/O cycles (IOM=1).
- `WAIT_STATES`, 0: number of extra READY-low cycles, range 0..7.

Ports:
- `CLK` in 1: processor clock; all logic on its rising edge.
- `RESET` in 1: synchronous, active-low reset.
- `ALE` in 1: address latch enable, active high.
- `A` in 12: upper address bits [19:8].
- `AD` inout 8: multiplexed address/data [7:0]; driven only during the read-drive window, otherwise high-Z.
- `IOM` in 1: 1 = I/O cycle, 0 = memory cycle.
- `RD` in 1: read strobe, active low.
- `WR` in 1: write strobe, active low.
- `DEN` in 1: data enable, active low.
- `READY` out 1: wait-state request to the CPU; 0 inserts waits.
- `Address` out 20: latched cycle address.
- `sel` out 1: latched cycle targets this window.
- `mem_rd_en` out 1: one-cycle read pulse.
- `mem_rdata` in 8: memory data, valid exactly one cycle after `mem_rd_en`.
- `mem_wr_en` out 1: one-cycle write pulse.
- `mem_wdata` out 8: captured write data.
- `bus_err` out 1: sticky protocol-error flag.

## Operation
- States: IDLE, SELECTED, RD_WAIT, RD_HOLD, WR_WAIT, WR_HOLD.
- ALE=1 in any state:
  - Latch `Address={A,AD}`.
  - Latch `sel` = (IOM==IS_IO) && (Address[19:WIN_LOG2]==BASE_ADDR[19:WIN_LOG2]).
  - Go to SELECTED if `sel`, else IDLE.
  - Any in-flight cycle is aborted and no pending write is committed.
- SELECTED, RD=0, WR=1:
  - Outputs `mem_rd_en=1` and `READY=0`.
  - Counter loads WAIT_STATES.
  - Next state RD_WAIT.
- SELECTED, WR=0, RD=1:
  - Capture `mem_wdata=AD` and load the counter with WAIT_STATES.
  - If WAIT_STATES=0: output `mem_wr_en=1`, keep `READY=1`, next state WR_HOLD.
  - Otherwise: output `READY=0`, next state WR_WAIT.
- SELECTED, RD=0 and WR=0: set `bus_err`, stay in SELECTED, issue no pulse.
- RD_WAIT:
  - First cycle: capture `mem_rdata` into the read register.
  - Counter decrements each cycle.
  - When the counter is 0: `READY=1`, next state RD_HOLD.
- RD_HOLD:
  - Drive AD with the read register while RD=0 and DEN=0.
  - On RD=1, go to IDLE.
- WR_WAIT:
  - Decrement the counter.
  - At the edge where it reaches 0: output `mem_wr_en=1` and `READY=1`, next state WR_HOLD.
- WR_HOLD: on WR=1, go to IDLE.
- Unselected cycles never touch READY, AD, or the memory pulses.
- `bus_err` clears only on reset.

## Timing
- Reset values:
  - `READY=1`, AD high-Z.
  - `mem_rd_en=0`, `mem_wr_en=0`.
  - `Address=0`, `sel=0`, `mem_wdata=0`, `bus_err=0`.
  - State IDLE.
- All outputs are registered except the AD output enable, which is state-registered and gated combinationally by RD and DEN.
- Read, with E0 the edge that samples RD=0:
  - `mem_rd_en` is high for exactly E0→E1.
  - `mem_rdata` is sampled at E1.
  - READY is low from E0 to E(1+WAIT_STATES).
  - AD is driven from E(1+WAIT_STATES) until RD=1.
- Write, with E0 the edge that samples WR=0:
  - READY is low for exactly WAIT_STATES cycles.
  - `mem_wr_en` pulses for one cycle starting at E(WAIT_STATES).
- Back-to-back cycles: an ALE one cycle after the strobe rises is accepted with no gap.
- Reset asserted mid-cycle returns to IDLE and releases AD on the same edge; no write pulse is emitted.

## Structure
- Package `i8088_bus_pkg` holds:
  - The state enum.
  - `ADDR_W=20` and `DATA_W=8`.
  - `MAX_WAIT=7` and the counter width (3).
- Sub-module `i8088_addr_decode`: a registered ALE address latch plus the window compare, producing `Address` and `sel`.
- The FSM, counter, and AD tristate live in the top.

## Test plan
- Reset: hold RESET=0 for 2 cycles → READY=1, AD=Z, `Address=0`, all pulses 0.
- Memory read at 20'h01234 with BASE=0, WIN_LOG2=16, WAIT_STATES=2, `mem_rdata`=8'hA5 → `sel=1`, one `mem_rd_en` pulse, READY low for 3 cycles, AD=8'hA5 while RD=0 and DEN=0.
- Write 8'h3C to 20'h00010 with WAIT_STATES=0 → `mem_wdata=8'h3C`, single `mem_wr_en` pulse at E0, READY never low.
- Out-of-window cycles: address 20'h10000 with WIN_LOG2=16, and an I/O cycle with IS_IO=0 → `sel=0`, no pulses, AD stays Z, READY=1.
- Simultaneous RD=0 and WR=0 while SELECTED → `bus_err=1` and stays set; no memory pulse.
- Mid-cycle aborts:
  - ALE during WR_WAIT (WAIT_STATES=3) → no `mem_wr_en`, new address latched.
  - RESET=0 during RD_HOLD → AD=Z on the next edge.

Source files
------------

// File: rtl/i8088_bus_pkg.sv
// Shared definitions for the 8088 bus-cycle slave.
//   ADDR_W / DATA_W : width of the demultiplexed address and of the data bus
//   MAX_WAIT        : largest wait-state count the counter can hold
//   CNT_W           : wait-state counter width
//   state_t         : bus-cycle FSM states
package i8088_bus_pkg;

    localparam int ADDR_W   = 20;
    localparam int DATA_W   = 8;
    localparam int MAX_WAIT = 7;
    localparam int CNT_W    = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SELECTED,
        ST_RD_WAIT,
        ST_RD_HOLD,
        ST_WR_WAIT,
        ST_WR_HOLD
    } state_t;

endpackage

// File: rtl/i8088_bus_slave_if.sv
// 8088 control/address pin group seen by the bus slave.
//   ALE, A[19:8], IOM, RD, WR, DEN : driven by the processor (master)
//   READY                          : wait-state request from the slave
// AD is bidirectional and stays a plain net port on the slave.
interface i8088_bus_slave_if;
    import i8088_bus_pkg::*;

    logic                     ALE;
    logic [ADDR_W-DATA_W-1:0] A;
    logic                     IOM;
    logic                     RD;
    logic                     WR;
    logic                     DEN;
    logic                     READY;

    modport master (output ALE, A, IOM, RD, WR, DEN, input READY);
    modport slave  (input  ALE, A, IOM, RD, WR, DEN, output READY);

endinterface

// File: rtl/i8088_addr_decode.sv
// ALE address latch and window compare.
//   clk, rst_n : clock, synchronous active-low reset
//   ale        : latch strobe
//   a, ad      : upper address pins and multiplexed low byte
//   iom        : cycle type (1 = I/O)
//   hit        : combinational window match of the current pins
//   address    : latched 20-bit address
//   sel        : latched window match
module i8088_addr_decode
    import i8088_bus_pkg::*;
#(
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int                WIN_LOG2  = 16,
    parameter bit                IS_IO     = 1'b0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ale,
    input  logic [ADDR_W-DATA_W-1:0] a,
    input  logic [DATA_W-1:0]        ad,
    input  logic                     iom,
    output logic                     hit,
    output logic [ADDR_W-1:0]        address,
    output logic                     sel
);

    logic [ADDR_W-1:0] bus_addr;

    assign bus_addr = {a, ad};

    // Shifting instead of slicing keeps WIN_LOG2 = ADDR_W legal (whole space).
    assign hit = (iom == IS_IO) &&
                 ((bus_addr >> WIN_LOG2) == (BASE_ADDR >> WIN_LOG2));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            address <= '0;
            sel     <= 1'b0;
        end else if (ale) begin
            address <= bus_addr;
            sel     <= hit;
        end
    end

endmodule

// File: rtl/i8088_bus_slave.sv
// 8088 bus-cycle slave: demultiplexes AD on ALE, decodes one window, turns
// RD/WR strobes into single-cycle memory pulses, inserts wait states via
// READY and drives read data back onto AD.
//   CLK, RESET       : clock, synchronous active-low reset
//   bus              : processor pin group (ALE, A, IOM, RD, WR, DEN, READY)
//   AD               : multiplexed address/data, driven only in RD_HOLD
//   Address, sel     : latched cycle address and window hit
//   mem_rd_en        : one-cycle read pulse; mem_rdata sampled one cycle later
//   mem_wr_en        : one-cycle write pulse with mem_wdata
//   bus_err          : sticky flag for RD and WR low together
module i8088_bus_slave
    import i8088_bus_pkg::*;
#(
    parameter logic [ADDR_W-1:0] BASE_ADDR   = 20'h00000,
    parameter int                WIN_LOG2    = 16,
    parameter bit                IS_IO       = 1'b0,
    parameter int                WAIT_STATES = 0
) (
    input  logic               CLK,
    input  logic               RESET,
    i8088_bus_slave_if.slave   bus,
    inout  wire  [DATA_W-1:0]  AD,
    output logic [ADDR_W-1:0]  Address,
    output logic               sel,
    output logic               mem_rd_en,
    input  logic [DATA_W-1:0]  mem_rdata,
    output logic               mem_wr_en,
    output logic [DATA_W-1:0]  mem_wdata,
    output logic               bus_err
);

    localparam int              WS_INT = (WAIT_STATES > MAX_WAIT) ? MAX_WAIT : WAIT_STATES;
    localparam logic [CNT_W-1:0] WS    = WS_INT[CNT_W-1:0];

    state_t            state, state_d;
    logic [CNT_W-1:0]  cnt, cnt_d;
    logic              ready_q, ready_d;
    logic              rd_en_d, wr_en_d, err_d;
    logic [DATA_W-1:0] wdata_d;
    logic [DATA_W-1:0] rdreg;
    logic              hit;
    logic              ad_oe;

    i8088_addr_decode #(
        .BASE_ADDR (BASE_ADDR),
        .WIN_LOG2  (WIN_LOG2),
        .IS_IO     (IS_IO)
    ) u_decode (
        .clk     (CLK),
        .rst_n   (RESET),
        .ale     (bus.ALE),
        .a       (bus.A),
        .ad      (AD),
        .iom     (bus.IOM),
        .hit     (hit),
        .address (Address),
        .sel     (sel)
    );

    assign bus.READY = ready_q;

    // Output enable is state-registered; RD/DEN gate it so the bus is
    // released the moment the processor lets go of the strobe.
    assign ad_oe = (state == ST_RD_HOLD) && !bus.RD && !bus.DEN;
    assign AD    = ad_oe ? rdreg : {DATA_W{1'bz}};

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        ready_d = ready_q;
        rd_en_d = 1'b0;
        wr_en_d = 1'b0;
        wdata_d = mem_wdata;
        err_d   = bus_err;

        if (bus.ALE) begin
            // A new address phase aborts whatever cycle was in flight.
            state_d = hit ? ST_SELECTED : ST_IDLE;
            ready_d = 1'b1;
        end else begin
            unique case (state)
                ST_SELECTED: begin
                    if (!bus.RD && !bus.WR) begin
                        err_d = 1'b1;
                    end else if (!bus.RD) begin
                        rd_en_d = 1'b1;
                        ready_d = 1'b0;
                        cnt_d   = WS;
                        state_d = ST_RD_WAIT;
                    end else if (!bus.WR) begin
                        wdata_d = AD;
                        cnt_d   = WS;
                        if (WS == '0) begin
                            wr_en_d = 1'b1;
                            state_d = ST_WR_HOLD;
                        end else begin
                            ready_d = 1'b0;
                            state_d = ST_WR_WAIT;
                        end
                    end
                end
                ST_RD_WAIT: begin
                    if (cnt == '0) begin
                        ready_d = 1'b1;
                        state_d = ST_RD_HOLD;
                    end else begin
                        cnt_d = cnt - CNT_W'(1);
                    end
                end
                ST_RD_HOLD: begin
                    if (bus.RD) state_d = ST_IDLE;
                end
                ST_WR_WAIT: begin
                    // Commit on the edge where the counter reaches zero.
                    cnt_d = cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        wr_en_d = 1'b1;
                        ready_d = 1'b1;
                        state_d = ST_WR_HOLD;
                    end
                end
                ST_WR_HOLD: begin
                    if (bus.WR) state_d = ST_IDLE;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            ready_q   <= 1'b1;
            mem_rd_en <= 1'b0;
            mem_wr_en <= 1'b0;
            mem_wdata <= '0;
            bus_err   <= 1'b0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            ready_q   <= ready_d;
            mem_rd_en <= rd_en_d;
            mem_wr_en <= wr_en_d;
            mem_wdata <= wdata_d;
            bus_err   <= err_d;
        end
    end

    // mem_rdata is valid in the cycle following the read pulse.
    always_ff @(posedge CLK) begin
        if (mem_rd_en) rdreg <= mem_rdata;
    end

endmodule

// File: tb/tb_i8088_bus_slave.sv
module tb_i8088_bus_slave;
    import i8088_bus_pkg::*;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic        RESET;
    logic        ale, iom, rd, wr, den;
    logic [11:0] a;
    logic [7:0]  tb_ad, rd_val, mem_rdata;
    logic        tb_ad_oe;

    wire  [7:0]  ad0, ad2, ad3;

    // Released AD reads back as 8'hFF through the pull-ups.
    for (genvar b = 0; b < 8; b++) begin : g_pu
        pullup (ad0[b]);
        pullup (ad2[b]);
        pullup (ad3[b]);
    end

    assign ad0 = tb_ad_oe ? tb_ad : 8'hzz;
    assign ad2 = tb_ad_oe ? tb_ad : 8'hzz;
    assign ad3 = tb_ad_oe ? tb_ad : 8'hzz;

    i8088_bus_slave_if bif0 ();
    i8088_bus_slave_if bif2 ();
    i8088_bus_slave_if bif3 ();

    assign bif0.ALE = ale; assign bif0.A = a; assign bif0.IOM = iom;
    assign bif0.RD  = rd;  assign bif0.WR = wr; assign bif0.DEN = den;
    assign bif2.ALE = ale; assign bif2.A = a; assign bif2.IOM = iom;
    assign bif2.RD  = rd;  assign bif2.WR = wr; assign bif2.DEN = den;
    assign bif3.ALE = ale; assign bif3.A = a; assign bif3.IOM = iom;
    assign bif3.RD  = rd;  assign bif3.WR = wr; assign bif3.DEN = den;

    // Slot 0: WAIT_STATES=0, slot 1: WAIT_STATES=2, slot 2: WAIT_STATES=3
    logic [19:0] addr [3];
    logic        sel  [3];
    logic        rde  [3];
    logic        wre  [3];
    logic [7:0]  wd   [3];
    logic        err  [3];
    logic        rdy  [3];
    logic [7:0]  adv  [3];
    int          ws   [3];

    assign rdy[0] = bif0.READY; assign rdy[1] = bif2.READY; assign rdy[2] = bif3.READY;
    assign adv[0] = ad0;        assign adv[1] = ad2;        assign adv[2] = ad3;

    // Memory returns data in the cycle after the read pulse.
    assign mem_rdata = rde[1] ? rd_val : 8'h00;

    i8088_bus_slave #(.BASE_ADDR(20'h00000), .WIN_LOG2(16), .IS_IO(1'b0), .WAIT_STATES(0)) u0 (
        .CLK(CLK), .RESET(RESET), .bus(bif0), .AD(ad0), .Address(addr[0]), .sel(sel[0]),
        .mem_rd_en(rde[0]), .mem_rdata(mem_rdata), .mem_wr_en(wre[0]), .mem_wdata(wd[0]),
        .bus_err(err[0]));

    i8088_bus_slave #(.BASE_ADDR(20'h00000), .WIN_LOG2(16), .IS_IO(1'b0), .WAIT_STATES(2)) u2 (
        .CLK(CLK), .RESET(RESET), .bus(bif2), .AD(ad2), .Address(addr[1]), .sel(sel[1]),
        .mem_rd_en(rde[1]), .mem_rdata(mem_rdata), .mem_wr_en(wre[1]), .mem_wdata(wd[1]),
        .bus_err(err[1]));

    i8088_bus_slave #(.BASE_ADDR(20'h00000), .WIN_LOG2(16), .IS_IO(1'b0), .WAIT_STATES(3)) u3 (
        .CLK(CLK), .RESET(RESET), .bus(bif3), .AD(ad3), .Address(addr[2]), .sel(sel[2]),
        .mem_rd_en(rde[2]), .mem_rdata(mem_rdata), .mem_wr_en(wre[2]), .mem_wdata(wd[2]),
        .bus_err(err[2]));

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Scoreboard: one queue of expected memory pulses per DUT slot.
    typedef struct packed {
        logic        wr;
        logic [19:0] addr;
        logic [7:0]  data;
    } sb_t;

    sb_t q0[$];
    sb_t q1[$];
    sb_t q2[$];

    task automatic push(input logic [2:0] mask, input logic wr_i,
                        input logic [19:0] ad_i, input logic [7:0] d_i);
        sb_t e;
        e = {wr_i, ad_i, d_i};
        if (mask[0]) q0.push_back(e);
        if (mask[1]) q1.push_back(e);
        if (mask[2]) q2.push_back(e);
    endtask

    task automatic mon(input int i);
        sb_t e;
        bit  have;
        have = 1'b0;
        e    = '0;
        if (!(rde[i] || wre[i])) return;
        case (i)
            0: if (q0.size() != 0) begin e = q0.pop_front(); have = 1'b1; end
            1: if (q1.size() != 0) begin e = q1.pop_front(); have = 1'b1; end
            2: if (q2.size() != 0) begin e = q2.pop_front(); have = 1'b1; end
            default: ;
        endcase
        if (!have) begin
            n_cmp++;
            n_fail++;
            $display("FAIL pulse_unexpected[%0d]: got rd=%0b wr=%0b expected no pulse (t=%0t)",
                     i, rde[i], wre[i], $time);
        end else begin
            chk($sformatf("pulse_kind[%0d]", i), 32'(wre[i]), 32'(e.wr));
            chk($sformatf("pulse_rd_only[%0d]", i), 32'(rde[i]), 32'(!e.wr));
            chk($sformatf("pulse_addr[%0d]", i), 32'(addr[i]), 32'(e.addr));
            if (e.wr) chk($sformatf("pulse_wdata[%0d]", i), 32'(wd[i]), 32'(e.data));
        end
    endtask

    always @(negedge CLK) begin
        for (int i = 0; i < 3; i++) mon(i);
    end

    task automatic tick;
        @(negedge CLK);
    endtask

    task automatic addr_phase(input logic [19:0] ad_i, input logic iom_i);
        ale      = 1'b1;
        a        = ad_i[19:8];
        tb_ad    = ad_i[7:0];
        tb_ad_oe = 1'b1;
        iom      = iom_i;
        tick;
        ale      = 1'b0;
        tb_ad_oe = 1'b0;
    endtask

    typedef struct {
        logic [19:0] addr;
        logic        iom;
        logic        exp_sel;
    } dec_vec_t;

    dec_vec_t vecs [6];

    initial begin
        vecs[0] = '{20'h01234, 1'b0, 1'b1};
        vecs[1] = '{20'h10000, 1'b0, 1'b0};
        vecs[2] = '{20'h0FFFF, 1'b0, 1'b1};
        vecs[3] = '{20'h00010, 1'b1, 1'b0};
        vecs[4] = '{20'hFFFFF, 1'b0, 1'b0};
        vecs[5] = '{20'h00000, 1'b0, 1'b1};
        ws[0] = 0; ws[1] = 2; ws[2] = 3;

        RESET = 1'b0; ale = 1'b0; iom = 1'b0; rd = 1'b1; wr = 1'b1; den = 1'b1;
        a = '0; tb_ad = '0; tb_ad_oe = 1'b0; rd_val = 8'h00;
        tick;
        tick;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst_ready[%0d]", i), 32'(rdy[i]), 32'd1);
            chk($sformatf("rst_ad[%0d]", i),    32'(adv[i]), 32'hFF);
            chk($sformatf("rst_addr[%0d]", i),  32'(addr[i]), 32'd0);
            chk($sformatf("rst_sel[%0d]", i),   32'(sel[i]), 32'd0);
            chk($sformatf("rst_rde[%0d]", i),   32'(rde[i]), 32'd0);
            chk($sformatf("rst_wre[%0d]", i),   32'(wre[i]), 32'd0);
            chk($sformatf("rst_wdata[%0d]", i), 32'(wd[i]), 32'd0);
            chk($sformatf("rst_err[%0d]", i),   32'(err[i]), 32'd0);
        end
        RESET = 1'b1;
        tick;

        // Window decode table.
        foreach (vecs[v]) begin
            addr_phase(vecs[v].addr, vecs[v].iom);
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("dec_sel[%0d][%0d]", v, i),  32'(sel[i]), 32'(vecs[v].exp_sel));
                chk($sformatf("dec_addr[%0d][%0d]", v, i), 32'(addr[i]), 32'(vecs[v].addr));
                chk($sformatf("dec_ready[%0d][%0d]", v, i), 32'(rdy[i]), 32'd1);
            end
        end

        // Memory read with wait states; AD driven from E(1+WAIT_STATES).
        rd_val = 8'hA5;
        addr_phase(20'h01234, 1'b0);
        push(3'b111, 1'b0, 20'h01234, 8'h00);
        rd = 1'b0; den = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick;
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("rd_ready[k%0d][%0d]", k, i), 32'(rdy[i]), 32'(k >= 1 + ws[i]));
                chk($sformatf("rd_ad[k%0d][%0d]", k, i), 32'(adv[i]),
                    (k >= 1 + ws[i]) ? 32'hA5 : 32'hFF);
            end
        end
        den = 1'b1; #1;
        chk("rd_den_gate", 32'(adv[1]), 32'hFF);
        den = 1'b0; #1;
        chk("rd_den_regate", 32'(adv[1]), 32'hA5);
        rd = 1'b1; den = 1'b1;
        tick;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rd_end_ready[%0d]", i), 32'(rdy[i]), 32'd1);
            chk($sformatf("rd_end_ad[%0d]", i),    32'(adv[i]), 32'hFF);
        end

        // Write; pulse at E(WAIT_STATES), READY low for WAIT_STATES cycles.
        addr_phase(20'h00010, 1'b0);
        push(3'b111, 1'b1, 20'h00010, 8'h3C);
        wr = 1'b0; tb_ad = 8'h3C; tb_ad_oe = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick;
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("wr_ready[k%0d][%0d]", k, i), 32'(rdy[i]), 32'(k >= ws[i]));
                chk($sformatf("wr_pulse[k%0d][%0d]", k, i), 32'(wre[i]), 32'(k == ws[i]));
            end
        end
        wr = 1'b1; tb_ad_oe = 1'b0;
        tick;
        for (int i = 0; i < 3; i++)
            chk($sformatf("wr_wdata[%0d]", i), 32'(wd[i]), 32'h3C);

        // Out-of-window memory read: nothing on the bus changes.
        addr_phase(20'h10000, 1'b0);
        rd = 1'b0; den = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick;
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("oow_ready[k%0d][%0d]", k, i), 32'(rdy[i]), 32'd1);
                chk($sformatf("oow_ad[k%0d][%0d]", k, i),    32'(adv[i]), 32'hFF);
            end
        end
        rd = 1'b1; den = 1'b1;
        tick;

        // I/O write into a memory slave: ignored.
        addr_phase(20'h00010, 1'b1);
        wr = 1'b0; tb_ad = 8'hEE; tb_ad_oe = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick;
            for (int i = 0; i < 3; i++)
                chk($sformatf("io_ready[k%0d][%0d]", k, i), 32'(rdy[i]), 32'd1);
        end
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("io_sel[%0d]", i),   32'(sel[i]), 32'd0);
            chk($sformatf("io_wdata[%0d]", i), 32'(wd[i]), 32'h3C);
        end
        wr = 1'b1; tb_ad_oe = 1'b0;
        tick;

        // ALE two cycles into a write: slots with wait states must not commit.
        addr_phase(20'h00020, 1'b0);
        push(3'b001, 1'b1, 20'h00020, 8'h77);
        wr = 1'b0; tb_ad = 8'h77; tb_ad_oe = 1'b1;
        tick;
        tick;
        wr = 1'b1; ale = 1'b1; a = 12'h004; tb_ad = 8'h56; iom = 1'b0;
        tick;
        ale = 1'b0; tb_ad_oe = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("abort_addr[%0d]", i),  32'(addr[i]), 32'h00456);
            chk($sformatf("abort_sel[%0d]", i),   32'(sel[i]), 32'd1);
            chk($sformatf("abort_ready[%0d]", i), 32'(rdy[i]), 32'd1);
            chk($sformatf("abort_wre[%0d]", i),   32'(wre[i]), 32'd0);
        end
        tick;
        tick;

        // RD and WR low together: sticky error, no pulse.
        rd = 1'b0; wr = 1'b0;
        tick;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("err_set[%0d]", i),   32'(err[i]), 32'd1);
            chk($sformatf("err_rde[%0d]", i),   32'(rde[i]), 32'd0);
            chk($sformatf("err_ready[%0d]", i), 32'(rdy[i]), 32'd1);
        end
        rd = 1'b1; wr = 1'b1;
        tick;
        tick;
        for (int i = 0; i < 3; i++)
            chk($sformatf("err_sticky[%0d]", i), 32'(err[i]), 32'd1);

        // Read, then ALE one cycle after RD rises, then a write.
        rd_val = 8'hC3;
        push(3'b111, 1'b0, 20'h00456, 8'h00);
        rd = 1'b0; den = 1'b0;
        repeat (5) tick;
        for (int i = 0; i < 3; i++)
            chk($sformatf("b2b_rd_ad[%0d]", i), 32'(adv[i]), 32'hC3);
        rd = 1'b1; den = 1'b1;
        tick;
        addr_phase(20'h00011, 1'b0);
        push(3'b111, 1'b1, 20'h00011, 8'h5A);
        wr = 1'b0; tb_ad = 8'h5A; tb_ad_oe = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick;
            for (int i = 0; i < 3; i++)
                chk($sformatf("b2b_wr_pulse[k%0d][%0d]", k, i), 32'(wre[i]), 32'(k == ws[i]));
        end
        wr = 1'b1; tb_ad_oe = 1'b0;
        tick;
        for (int i = 0; i < 3; i++)
            chk($sformatf("b2b_addr[%0d]", i), 32'(addr[i]), 32'h00011);

        // Reset while AD is being driven releases it on the reset edge.
        rd_val = 8'h99;
        addr_phase(20'h01234, 1'b0);
        push(3'b111, 1'b0, 20'h01234, 8'h00);
        rd = 1'b0; den = 1'b0;
        repeat (5) tick;
        for (int i = 0; i < 3; i++)
            chk($sformatf("hold_ad[%0d]", i), 32'(adv[i]), 32'h99);
        RESET = 1'b0;
        tick;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("mrst_ad[%0d]", i),    32'(adv[i]), 32'hFF);
            chk($sformatf("mrst_ready[%0d]", i), 32'(rdy[i]), 32'd1);
            chk($sformatf("mrst_err[%0d]", i),   32'(err[i]), 32'd0);
            chk($sformatf("mrst_addr[%0d]", i),  32'(addr[i]), 32'd0);
            chk($sformatf("mrst_wdata[%0d]", i), 32'(wd[i]), 32'd0);
        end
        RESET = 1'b1; rd = 1'b1; den = 1'b1;
        tick;
        tick;

        chk("sb_drain", 32'(q0.size() + q1.size() + q2.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
